// File: rtl/mem_arb_if.sv
// Request/grant and memory-port signals of mem_arb, grouped with arbiter-side (slave)
// and requester/memory-side (master) views.
interface mem_arb_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          ls_req;
  logic          ls_we;
  logic [BW-1:0] ls_be;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic          ls_gnt;
  logic          ls_rvalid;
  logic [DW-1:0] ls_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [BW-1:0] mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arb.sv
// Single-port memory arbiter: fetch vs load/store, LS priority with a streak limit
// that guarantees fetch progress, fixed wait states, one rvalid pulse per access.
module mem_arb #(
  parameter int unsigned WAIT_STATES   = 0,
  parameter int unsigned LS_STREAK_MAX = 2
) (
  input  logic      clk,
  input  logic      rst,
  mem_arb_if.slave  bus
);
  localparam int unsigned CNT_W = 3;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned BW    = 4;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_streak;
  logic [CNT_W-1:0] r_wcnt;
  logic             r_own_ls;
  logic             r_we;
  logic [BW-1:0]    r_be;
  logic [AW-1:0]    r_addr;
  logic [DW-1:0]    r_wdata;

  logic             w_arb;
  logic             w_if_win;
  logic             w_if_gnt;
  logic             w_ls_gnt;
  logic             w_resp;

  // Arbitration, next state and output decode
  always_comb begin
    w_state_nxt    = r_state;
    w_arb          = (r_state == S_IDLE) || (r_state == S_RESP);
    w_if_win       = bus.if_req && (!bus.ls_req || (r_streak == CNT_W'(LS_STREAK_MAX)));
    w_if_gnt       = rst && w_arb && w_if_win;
    w_ls_gnt       = rst && w_arb && bus.ls_req && !w_if_win;
    w_resp         = (r_state == S_RESP);

    case (r_state)
      S_IDLE, S_RESP: w_state_nxt = (w_if_gnt || w_ls_gnt) ? S_ISSUE : S_IDLE;
      S_ISSUE:        w_state_nxt = (WAIT_STATES != 0) ? S_WAIT : S_RESP;
      S_WAIT:         if (r_wcnt <= CNT_W'(1)) w_state_nxt = S_RESP;
      default:        w_state_nxt = S_IDLE;
    endcase

    bus.if_gnt    = w_if_gnt;
    bus.ls_gnt    = w_ls_gnt;
    bus.mem_en    = (r_state == S_ISSUE);
    bus.mem_we    = (r_state == S_ISSUE) && r_we;
    bus.mem_be    = r_be;
    bus.mem_addr  = r_addr;
    bus.mem_wdata = r_wdata;
    bus.if_rvalid = w_resp && !r_own_ls;
    bus.ls_rvalid = w_resp && r_own_ls;
    bus.if_rdata  = (w_resp && !r_own_ls) ? bus.mem_rdata : DW'(0);
    // A store completion returns zero data
    bus.ls_rdata  = (w_resp && r_own_ls && !r_we) ? bus.mem_rdata : DW'(0);
    bus.busy      = (r_state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_streak <= '0;
      r_wcnt   <= '0;
      r_own_ls <= 1'b0;
      r_we     <= 1'b0;
      r_be     <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_if_gnt) begin
        r_own_ls <= 1'b0;
        r_we     <= 1'b0;
        r_be     <= BW'(4'hF);
        r_addr   <= bus.if_addr;
        r_wdata  <= '0;
        r_streak <= '0;
      end else if (w_ls_gnt) begin
        r_own_ls <= 1'b1;
        r_we     <= bus.ls_we;
        r_be     <= bus.ls_be;
        r_addr   <= bus.ls_addr;
        r_wdata  <= bus.ls_wdata;
        if (r_streak < CNT_W'(LS_STREAK_MAX)) r_streak <= r_streak + CNT_W'(1);
      end
      // Wait counter loads on grant (entering ISSUE) and counts down through WAIT
      if (w_if_gnt || w_ls_gnt) r_wcnt <= CNT_W'(WAIT_STATES);
      else if (r_state == S_WAIT) r_wcnt <= r_wcnt - CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: three instances cover WAIT_STATES of 0, 2 and 3.
module tb_mem_arb;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  mem_arb_if bus_a ();
  mem_arb_if bus_b ();
  mem_arb_if bus_c ();

  mem_arb #(.WAIT_STATES(0), .LS_STREAK_MAX(2)) u_w0 (.clk(clk), .rst(rst), .bus(bus_a));
  mem_arb #(.WAIT_STATES(2), .LS_STREAK_MAX(2)) u_w2 (.clk(clk), .rst(rst), .bus(bus_b));
  mem_arb #(.WAIT_STATES(3), .LS_STREAK_MAX(2)) u_w3 (.clk(clk), .rst(rst), .bus(bus_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  logic [5:0] exp_ls_order;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    exp_ls_order = 6'b011011;

    bus_a.if_req = 1'b1;          bus_a.if_addr  = $urandom;
    bus_a.ls_req = 1'b1;          bus_a.ls_we    = 1'($urandom);
    bus_a.ls_be  = 4'($urandom);  bus_a.ls_addr  = $urandom;
    bus_a.ls_wdata = $urandom;    bus_a.mem_rdata = $urandom;
    bus_b.if_req = 1'b1; bus_b.if_addr = '0; bus_b.ls_req = 1'b1; bus_b.ls_we = 1'b0;
    bus_b.ls_be = '0; bus_b.ls_addr = '0; bus_b.ls_wdata = '0; bus_b.mem_rdata = '0;
    bus_c.if_req = 1'b1; bus_c.if_addr = '0; bus_c.ls_req = 1'b1; bus_c.ls_we = 1'b0;
    bus_c.ls_be = '0; bus_c.ls_addr = '0; bus_c.ls_wdata = '0; bus_c.mem_rdata = '0;

    // Reset with requests pending: everything must read 0
    #1 rst = 1'b0;
    #2;
    chk("rst_if_gnt",    32'(bus_a.if_gnt),    32'h0);
    chk("rst_ls_gnt",    32'(bus_a.ls_gnt),    32'h0);
    chk("rst_if_rvalid", 32'(bus_a.if_rvalid), 32'h0);
    chk("rst_ls_rvalid", 32'(bus_a.ls_rvalid), 32'h0);
    chk("rst_if_rdata",  bus_a.if_rdata,       32'h0);
    chk("rst_ls_rdata",  bus_a.ls_rdata,       32'h0);
    chk("rst_mem_en",    32'(bus_a.mem_en),    32'h0);
    chk("rst_mem_we",    32'(bus_a.mem_we),    32'h0);
    chk("rst_mem_be",    32'(bus_a.mem_be),    32'h0);
    chk("rst_mem_addr",  bus_a.mem_addr,       32'h0);
    chk("rst_mem_wdata", bus_a.mem_wdata,      32'h0);
    chk("rst_busy",      32'(bus_a.busy),      32'h0);
    chk("rst_b_gnt",     32'(bus_b.ls_gnt),    32'h0);
    chk("rst_c_gnt",     32'(bus_c.ls_gnt),    32'h0);

    bus_a.if_req = 1'b0; bus_a.ls_req = 1'b0;
    bus_b.if_req = 1'b0; bus_b.ls_req = 1'b0;
    bus_c.if_req = 1'b0; bus_c.ls_req = 1'b0;
    cyc();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("idle_busy",   32'(bus_a.busy),   32'h0);
      chk("idle_mem_en", 32'(bus_a.mem_en), 32'h0);
    end

    // Single fetch, zero wait states
    bus_a.if_req = 1'b1; bus_a.if_addr = 32'h100; bus_a.mem_rdata = 32'h00500093;
    #1;
    chk("f_if_gnt", 32'(bus_a.if_gnt), 32'h1);
    chk("f_ls_gnt", 32'(bus_a.ls_gnt), 32'h0);
    cyc();
    bus_a.if_req = 1'b0;
    #1;
    chk("f_mem_en",   32'(bus_a.mem_en), 32'h1);
    chk("f_mem_addr", bus_a.mem_addr,    32'h100);
    chk("f_mem_be",   32'(bus_a.mem_be), 32'hF);
    chk("f_mem_we",   32'(bus_a.mem_we), 32'h0);
    cyc();
    chk("f_if_rvalid", 32'(bus_a.if_rvalid), 32'h1);
    chk("f_if_rdata",  bus_a.if_rdata,       32'h00500093);
    chk("f_ls_rvalid", 32'(bus_a.ls_rvalid), 32'h0);
    cyc();
    chk("f_post_rvalid", 32'(bus_a.if_rvalid), 32'h0);
    chk("f_post_rdata",  bus_a.if_rdata,       32'h0);
    chk("f_post_addr",   bus_a.mem_addr,       32'h100);
    chk("f_post_busy",   32'(bus_a.busy),      32'h0);

    // Store then load, two wait states
    bus_b.ls_req = 1'b1; bus_b.ls_we = 1'b1; bus_b.ls_be = 4'h3;
    bus_b.ls_addr = 32'h2000; bus_b.ls_wdata = 32'hBEEF; bus_b.mem_rdata = 32'hDEADBEEF;
    #1;
    chk("st_gnt", 32'(bus_b.ls_gnt), 32'h1);
    cyc();
    bus_b.ls_we = 1'b0; bus_b.ls_be = 4'hF;
    #1;
    chk("st_mem_en",    32'(bus_b.mem_en), 32'h1);
    chk("st_mem_we",    32'(bus_b.mem_we), 32'h1);
    chk("st_mem_be",    32'(bus_b.mem_be), 32'h3);
    chk("st_mem_addr",  bus_b.mem_addr,    32'h2000);
    chk("st_mem_wdata", bus_b.mem_wdata,   32'hBEEF);
    chk("st_issue_gnt", 32'(bus_b.ls_gnt), 32'h0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("st_wait_en",     32'(bus_b.mem_en),    32'h0);
      chk("st_wait_rvalid", 32'(bus_b.ls_rvalid), 32'h0);
      chk("st_wait_gnt",    32'(bus_b.ls_gnt),    32'h0);
    end
    cyc();
    #1;
    chk("st_rvalid",   32'(bus_b.ls_rvalid), 32'h1);
    chk("st_rdata",    bus_b.ls_rdata,       32'h0);
    chk("ld_gnt_resp", 32'(bus_b.ls_gnt),    32'h1);
    cyc();
    bus_b.ls_req = 1'b0;
    #1;
    chk("ld_mem_en", 32'(bus_b.mem_en), 32'h1);
    chk("ld_mem_we", 32'(bus_b.mem_we), 32'h0);
    chk("ld_mem_be", 32'(bus_b.mem_be), 32'hF);
    cyc();
    chk("ld_wait_rvalid", 32'(bus_b.ls_rvalid), 32'h0);
    cyc();
    chk("ld_wait_rvalid", 32'(bus_b.ls_rvalid), 32'h0);
    cyc();
    bus_b.mem_rdata = 32'h0000BEEF;
    #1;
    chk("ld_rvalid", 32'(bus_b.ls_rvalid), 32'h1);
    chk("ld_rdata",  bus_b.ls_rdata,       32'h0000BEEF);
    cyc();
    chk("ld_post_busy", 32'(bus_b.busy), 32'h0);

    // Contention: both held, order LS LS IF LS LS IF
    bus_a.if_req = 1'b1; bus_a.if_addr = 32'h200;
    bus_a.ls_req = 1'b1; bus_a.ls_we = 1'b0; bus_a.ls_be = 4'hF; bus_a.ls_addr = 32'h3000;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("ct_ls_gnt", 32'(bus_a.ls_gnt), 32'(exp_ls_order[k]));
      chk("ct_if_gnt", 32'(bus_a.if_gnt), 32'(!exp_ls_order[k]));
      cyc();
      chk("ct_issue_both", 32'(bus_a.if_gnt | bus_a.ls_gnt), 32'h0);
      cyc();
    end
    bus_a.if_req = 1'b0; bus_a.ls_req = 1'b0;
    cyc();

    // LS streak with no fetch pending, then fetch wins once streak is saturated
    bus_a.ls_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("pr_ls_gnt", 32'(bus_a.ls_gnt), 32'h1);
      cyc();
      if (k == 2) bus_a.if_req = 1'b1;
      cyc();
    end
    #1;
    chk("pr_if_gnt", 32'(bus_a.if_gnt), 32'h1);
    chk("pr_ls_off", 32'(bus_a.ls_gnt), 32'h0);
    cyc();
    bus_a.if_req = 1'b0; bus_a.ls_req = 1'b0;
    cyc();
    cyc();

    // Mid-access reset with three wait states
    bus_c.ls_req = 1'b1; bus_c.ls_we = 1'b0; bus_c.ls_be = 4'hF; bus_c.ls_addr = 32'h40;
    bus_c.mem_rdata = 32'hCAFEF00D;
    #1;
    chk("mr_gnt", 32'(bus_c.ls_gnt), 32'h1);
    cyc();
    bus_c.ls_req = 1'b0;
    cyc();
    chk("mr_wait_busy", 32'(bus_c.busy), 32'h1);
    rst = 1'b0;
    #1;
    chk("mr_busy",   32'(bus_c.busy),      32'h0);
    chk("mr_mem_en", 32'(bus_c.mem_en),    32'h0);
    chk("mr_addr",   bus_c.mem_addr,       32'h0);
    chk("mr_rvalid", 32'(bus_c.ls_rvalid), 32'h0);
    cyc();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("mr_no_rvalid", 32'(bus_c.ls_rvalid), 32'h0);
    end
    bus_c.ls_req = 1'b1; bus_c.ls_addr = 32'h44; bus_c.mem_rdata = 32'h12345678;
    #1;
    chk("mr2_gnt", 32'(bus_c.ls_gnt), 32'h1);
    cyc();
    bus_c.ls_req = 1'b0;
    #1;
    chk("mr2_mem_addr", bus_c.mem_addr, 32'h44);
    for (int i = 2; i < 5; i++) begin
      cyc();
      chk("mr2_wait_rvalid", 32'(bus_c.ls_rvalid), 32'h0);
    end
    cyc();
    chk("mr2_rvalid", 32'(bus_c.ls_rvalid), 32'h1);
    chk("mr2_rdata",  bus_c.ls_rdata,       32'h12345678);
    cyc();
    chk("mr2_post_busy", 32'(bus_c.busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arb.md
# mem_arb

Single-port memory arbiter between the instruction-fetch path and the load/store path of the core. It accepts a request from each side with a req/gnt handshake, serialises accesses onto one memory port with a configurable number of wait states, and returns read data with a one-cycle valid pulse per access. Load/store has priority over fetch, and a bounded streak counter prevents fetch starvation. With this block in place, the control unit no longer has to split loads into two phases.

## Interface
- WAIT_STATES, 0: extra memory cycles between issue and read data, legal range 0..7
- LS_STREAK_MAX, 2: consecutive load/store grants allowed while fetch is waiting, legal range 1..7
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, held until if_gnt
- if_addr  in  32  fetch word address
- if_gnt  out  1  fetch request accepted this cycle (combinational)
- if_rvalid  out  1  fetch data valid this cycle
- if_rdata  out  32  fetch data
- ls_req  in  1  load/store request, held until ls_gnt
- ls_we  in  1  1 = store, 0 = load
- ls_be  in  4  byte enables
- ls_addr  in  32  data address
- ls_wdata  in  32  store data
- ls_gnt  out  1  load/store request accepted this cycle (combinational)
- ls_rvalid  out  1  load data valid, or store complete
- ls_rdata  out  32  load data; 0 on store completion
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  memory write enable
- mem_be  out  4  memory byte enables
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data
- busy  out  1  access in flight (state != IDLE)

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Arbitration points: IDLE and RESP. At an arbitration point with a request pending, exactly one gnt is asserted and the next state is ISSUE.
  - The winner's owner (IF or LS), addr, we, be and wdata are captured on that clock edge.
  - A fetch capture forces we=0 and be=4'hF.
- Priority: LS wins, except when if_req=1 and the streak counter equals LS_STREAK_MAX. In that case IF wins.
- Streak counter, 3 bits:
  - an LS grant increments it, saturating at LS_STREAK_MAX;
  - an IF grant clears it to 0;
  - it is otherwise held.
- With no request at an arbitration point: IDLE stays IDLE, and RESP goes to IDLE.
- ISSUE, one cycle: mem_en=1, and mem_we/mem_be/mem_addr/mem_wdata are driven from the captured registers.
  - Next state is WAIT if WAIT_STATES>0, else RESP.
- WAIT: a down-counter loaded with WAIT_STATES on entering ISSUE. Stay in WAIT until the counter reaches 1, then go to RESP. WAIT lasts exactly WAIT_STATES cycles.
- RESP, one cycle: the owner's rvalid=1.
  - IF: if_rdata = mem_rdata.
  - LS load: ls_rdata = mem_rdata.
  - LS store: ls_rdata = 0.
  - The non-owner rvalid is 0.
- Outside ISSUE: mem_en=0 and mem_we=0. mem_addr, mem_wdata and mem_be hold their last value.
- Outside RESP: both rvalid=0 and both rdata=0.
- Requester rule: inputs must stay stable while req=1 and gnt=0. After gnt they may change freely. A req still high in the cycle after gnt counts as a new request.

## Timing
- Reset (rst=0, asynchronous):
  - state=IDLE, streak=0, wait counter=0, captured registers=0;
  - mem_en=mem_we=0, mem_be=0, mem_addr=mem_wdata=0;
  - both gnt=0, both rvalid=0, both rdata=0, busy=0.
  - gnt is forced to 0 while rst=0.
- Reset asserted mid-access: the access is abandoned and no rvalid is produced.
- Reset release: the first grant is possible in the first cycle with rst=1.
- Per-access latency, with grant in cycle G:
  - ISSUE in G+1;
  - RESP in G+2+WAIT_STATES.
- Back-to-back accesses: the next grant occurs in the RESP cycle, so throughput is one access per 2+WAIT_STATES cycles.
- Memory contract: mem_rdata is valid in the RESP cycle, i.e. WAIT_STATES+1 cycles after the mem_en cycle.
- Simultaneous if_req and ls_req with streak<LS_STREAK_MAX: ls_gnt=1, if_gnt=0, and if_req must remain held.
- if_gnt and ls_gnt are never both 1.

## Test plan
- Reset and idle: rst=0 with random inputs -> all outputs 0. Release with no requests for 10 cycles -> busy=0, mem_en=0 throughout.
- Single fetch, WAIT_STATES=0: if_req with if_addr=32'h100, mem_rdata=32'h00500093 ->
  - if_gnt in cycle 0;
  - mem_en=1, mem_addr=32'h100, mem_be=4'hF in cycle 1;
  - if_rvalid=1, if_rdata=32'h00500093 in cycle 2.
- Store then load, WAIT_STATES=2: store to 32'h2000 with be=4'h3 and wdata=32'hBEEF, then a load from the same address ->
  - store: mem_we=1, be=4'h3; ls_rvalid=1 with ls_rdata=0 four cycles after gnt;
  - load: ls_gnt in the store's RESP cycle; load rvalid eight cycles after the first grant.
- Contention, LS_STREAK_MAX=2: if_req and ls_req held continuously ->
  - grant order LS, LS, IF, LS, LS, IF;
  - never both gnt in the same cycle.
- Priority without starvation: ls_req held, if_req low -> LS granted every arbitration point. Raise if_req after the streak saturates -> IF granted at the next arbitration point.
- Mid-access reset, WAIT_STATES=3: assert rst during WAIT -> outputs immediately 0, no rvalid afterwards. A request after release completes normally.
